phase_receiver: RTL and testbench
=================================

Name: phase_receiver

Overview:
- Consumes the five phase strobes (clock0..clock4) from the SIMPLE processor's clock controller. This is the responder end of the phase-strobe interface.
- Checks strobe order and generates registered per-stage enables for the datapath.
- Counts completed instructions.
- Drives the halt request back to the controller's haltin when a halt instruction retires or a protocol violation is detected.

Parameters:
- ICOUNT_W, 16, width of the retired-instruction counter.
- STALL_LIMIT, 32, clock cycles allowed without a strobe mid-instruction (used only with the optional feature).

Ports:
- clock  in  1  system clock, same clock as the controller.
- reset_n  in  1  reset, asynchronous assert, active-low.
- phase_in  in  5  phase strobes; bit k = clock k from the controller.
- halt_req  in  1  decoder flag: the current instruction is HLT.
- exec_hold  in  1  controller exec-hold active; strobes legitimately paused.
- phase_en  out  5  one-hot, one-cycle stage enable, registered.
- phase_idx  out  3  index (0..4) of the next expected phase.
- inst_count  out  ICOUNT_W  retired-instruction count.
- haltout  out  1  halt request to the controller haltin; sticky.
- proto_err  out  1  protocol error flag; sticky.
- err_code  out  3  0 none, 1 overlap, 2 order, 3 post-halt, 4 stall.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - phase_en=0, phase_idx=0, inst_count=0, haltout=0, proto_err=0, err_code=0.
  - state=RUN.
- States: RUN, HALTED, ERROR.
- phase_in is sampled on every posedge clock. Inputs are already synchronous to clock.
- RUN, phase_in==0: hold all state; phase_en=0.
- RUN, phase_in one-hot with bit == phase_idx (accepted strobe):
  - Next cycle, phase_en = that one-hot value for exactly one cycle (latency 1).
  - phase_idx advances mod 5 (4 wraps to 0).
- Accepted strobe on phase 4:
  - inst_count increments, wrapping at 2^ICOUNT_W.
  - If halt_req is high in the same cycle: go to HALTED and set haltout=1 next cycle.
- halt_req is ignored on every other cycle.
- Error checks in RUN, highest priority first:
  1. phase_in has more than one bit set: err_code=1, go to ERROR.
  2. phase_in is one-hot but its bit != phase_idx: err_code=2, go to ERROR.
- HALTED:
  - phase_in==0: hold.
  - Any nonzero phase_in: err_code=3, go to ERROR. Overlap (code 1) still takes priority.
- ERROR:
  - proto_err=1 and haltout=1, both sticky.
  - phase_en is forced to 0.
  - phase_idx, inst_count and err_code are frozen.
  - Only reset_n leaves this state.
- Simultaneous events:
  - An error cycle produces no phase_en pulse and no count increment.
  - An accepted phase-4 strobe with halt_req both counts the instruction and halts.
- All outputs are registered. Nothing combinational flows from phase_in to any output.
- Reset asserted mid-instruction: immediate clear. The receiver then expects phase 0 regardless of where the controller is.

Optional Feature:
- Macro: PHASE_RECEIVER_STALL_WATCHDOG_EN.
- Defined: a stall counter runs in RUN while phase_idx != 0 and exec_hold == 0.
  - It clears on any strobe or whenever exec_hold is high.
  - When it reaches STALL_LIMIT: err_code=4, go to ERROR.
- Undefined: no counter is built. exec_hold is unused, and err_code value 4 never occurs.

Decomposition:
- Package simple_phase_pkg holds:
  - NPHASE=5;
  - the state enum (RUN, HALTED, ERROR);
  - error code constants ERR_NONE, ERR_OVERLAP, ERR_ORDER, ERR_POSTHALT, ERR_STALL.
- Sub-module phase_stall_watchdog (counter plus limit compare) is instantiated only under the macro.

Test Plan:
- Normal sequence: strobes 00001, 00010, 00100, 01000, 10000, each separated by one idle cycle, repeated 3 times.
  - Expect 15 phase_en pulses, each one cycle after its strobe.
  - inst_count=3, phase_idx=0, no error.
- Halt: halt_req=1 coincident with the second phase-4 strobe.
  - Expect inst_count=2 and haltout=1 next cycle.
  - A later strobe 00001 gives err_code=3, proto_err=1.
- Order error: after phase 0 is accepted, drive 00100.
  - Expect err_code=2, no phase_en pulse, phase_idx frozen at 1.
- Overlap: drive 00011 while in RUN.
  - Expect err_code=1 and haltout=1 next cycle.
  - Outputs stay frozen for 20 further strobes.
- Reset mid-instruction: assert reset_n=0 for 1 cycle after phase 2 is accepted.
  - Expect all outputs 0 immediately and phase_idx=0.
  - A following 00001 is accepted.
- Watchdog (macro defined, STALL_LIMIT=8):
  - After phase 1, hold 8 idle cycles: err_code=4.
  - Repeat with exec_hold=1 for 20 cycles: no error.

Source files
------------

// File: rtl/simple_phase_pkg.sv
// simple_phase_pkg: shared constants and types for the SIMPLE phase-strobe receiver.
//   NPHASE        number of phase strobes per instruction
//   phase_state_e receiver state (run / halted / error)
//   ERR_*         values reported on err_code
//   next_phase()  phase index increment, wrapping after the last phase
package simple_phase_pkg;

    localparam int unsigned NPHASE = 5;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StHalted = 2'd1,
        StError  = 2'd2
    } phase_state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_OVERLAP  = 3'd1;
    localparam logic [2:0] ERR_ORDER    = 3'd2;
    localparam logic [2:0] ERR_POSTHALT = 3'd3;
    localparam logic [2:0] ERR_STALL    = 3'd4;

    function automatic logic [2:0] next_phase(input logic [2:0] idx);
        return (idx == 3'(NPHASE - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/phase_receiver_if.sv
// phase_receiver_if: phase-strobe bus between the clock controller side and the receiver.
//   phase_in   [NPHASE]   strobes, bit k = clock k
//   halt_req              current instruction is HLT
//   exec_hold             controller exec-hold, strobes legitimately paused
//   phase_en   [NPHASE]   registered one-hot stage enable
//   phase_idx  [3]        next expected phase
//   inst_count [ICOUNT_W] retired-instruction count
//   haltout               halt request to controller haltin (sticky)
//   proto_err             protocol error flag (sticky)
//   err_code   [3]        reason for the error / halt
// Modports: master = controller/stimulus side, slave = receiver.
interface phase_receiver_if #(
    parameter int unsigned ICOUNT_W = 16
) ();
    import simple_phase_pkg::*;

    logic [NPHASE-1:0]   phase_in;
    logic                halt_req;
    logic                exec_hold;
    logic [NPHASE-1:0]   phase_en;
    logic [2:0]          phase_idx;
    logic [ICOUNT_W-1:0] inst_count;
    logic                haltout;
    logic                proto_err;
    logic [2:0]          err_code;

    modport master (
        output phase_in, halt_req, exec_hold,
        input  phase_en, phase_idx, inst_count, haltout, proto_err, err_code
    );

    modport slave (
        input  phase_in, halt_req, exec_hold,
        output phase_en, phase_idx, inst_count, haltout, proto_err, err_code
    );

endinterface

// File: rtl/phase_stall_watchdog.sv
// phase_stall_watchdog: counts consecutive enabled cycles and flags a stall on the
// STALL_LIMIT-th one. The counter clears whenever count_en_i is low.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   count_en_i     receiver is mid-instruction, idle and not held
//   stall_o        this cycle completes STALL_LIMIT idle cycles
// Only built when PHASE_RECEIVER_STALL_WATCHDOG_EN is defined.
`ifdef PHASE_RECEIVER_STALL_WATCHDOG_EN
module phase_stall_watchdog #(
    parameter int unsigned STALL_LIMIT = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic count_en_i,
    output logic stall_o
);

    localparam int unsigned CntW = $clog2(STALL_LIMIT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = count_en_i ? cnt_q + CntW'(1) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_o = count_en_i && (cnt_q == CntW'(STALL_LIMIT - 1));

endmodule
`endif

// File: rtl/phase_receiver.sv
// phase_receiver: responder end of the SIMPLE phase-strobe interface. Checks strobe order,
// issues registered one-cycle stage enables, counts retired instructions and raises the
// halt request on HLT retirement or on a protocol violation.
//   clock, reset_n  system clock, asynchronous active-low reset
//   bus (slave)     phase strobes in; enables, index, count, halt and error status out
// Optional: define PHASE_RECEIVER_STALL_WATCHDOG_EN to build the mid-instruction stall
// watchdog (error code 4); otherwise exec_hold is ignored.
module phase_receiver
    import simple_phase_pkg::*;
#(
    parameter int unsigned ICOUNT_W    = 16,
    parameter int unsigned STALL_LIMIT = 32
) (
    input logic             clock,
    input logic             reset_n,
    phase_receiver_if.slave bus
);

    phase_state_e        state_q, state_d;
    logic [NPHASE-1:0]   phase_en_q, phase_en_d;
    logic [2:0]          phase_idx_q, phase_idx_d;
    logic [ICOUNT_W-1:0] inst_count_q, inst_count_d;
    logic                haltout_q, haltout_d;
    logic                proto_err_q, proto_err_d;
    logic [2:0]          err_code_q, err_code_d;

    logic [NPHASE-1:0] expect_onehot;
    logic              any_hot, multi_hot, stall;
    logic              err_hit;
    logic [2:0]        err_val;

    assign any_hot       = |bus.phase_in;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hot     = (bus.phase_in & (bus.phase_in - NPHASE'(1))) != '0;
    assign expect_onehot = NPHASE'(1) << phase_idx_q;

`ifdef PHASE_RECEIVER_STALL_WATCHDOG_EN
    logic stall_cnt_en;
    assign stall_cnt_en = (state_q == StRun) && (phase_idx_q != 3'd0) && !bus.exec_hold
                          && !any_hot;

    phase_stall_watchdog #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_stall_watchdog (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .count_en_i(stall_cnt_en),
        .stall_o   (stall)
    );
`else
    localparam int unsigned UnusedStallLimit = STALL_LIMIT;
    logic unused_exec_hold;
    assign unused_exec_hold = bus.exec_hold;
    assign stall            = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        phase_en_d   = '0;
        phase_idx_d  = phase_idx_q;
        inst_count_d = inst_count_q;
        haltout_d    = haltout_q;
        proto_err_d  = proto_err_q;
        err_code_d   = err_code_q;
        err_hit      = 1'b0;
        err_val      = ERR_NONE;

        unique case (state_q)
            StRun: begin
                if (multi_hot) begin
                    err_hit = 1'b1;
                    err_val = ERR_OVERLAP;
                end else if (any_hot && (bus.phase_in != expect_onehot)) begin
                    err_hit = 1'b1;
                    err_val = ERR_ORDER;
                end else if (any_hot) begin
                    phase_en_d  = bus.phase_in;
                    phase_idx_d = next_phase(phase_idx_q);
                    if (phase_idx_q == 3'(NPHASE - 1)) begin
                        inst_count_d = inst_count_q + ICOUNT_W'(1);
                        // halt_req only matters on the retiring strobe
                        if (bus.halt_req) begin
                            state_d   = StHalted;
                            haltout_d = 1'b1;
                        end
                    end
                end else if (stall) begin
                    err_hit = 1'b1;
                    err_val = ERR_STALL;
                end
            end
            StHalted: begin
                if (multi_hot) begin
                    err_hit = 1'b1;
                    err_val = ERR_OVERLAP;
                end else if (any_hot) begin
                    err_hit = 1'b1;
                    err_val = ERR_POSTHALT;
                end
            end
            StError: begin
                // Everything frozen; only reset leaves.
            end
            default: state_d = StError;
        endcase

        if (err_hit) begin
            state_d     = StError;
            err_code_d  = err_val;
            proto_err_d = 1'b1;
            haltout_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StRun;
            phase_en_q   <= '0;
            phase_idx_q  <= '0;
            inst_count_q <= '0;
            haltout_q    <= 1'b0;
            proto_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            phase_en_q   <= phase_en_d;
            phase_idx_q  <= phase_idx_d;
            inst_count_q <= inst_count_d;
            haltout_q    <= haltout_d;
            proto_err_q  <= proto_err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.phase_en   = phase_en_q;
    assign bus.phase_idx  = phase_idx_q;
    assign bus.inst_count = inst_count_q;
    assign bus.haltout    = haltout_q;
    assign bus.proto_err  = proto_err_q;
    assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_phase_receiver.sv
// tb_phase_receiver: directed scenarios plus randomized strobe traffic for phase_receiver,
// compared every cycle against a behavioural model of the strobe protocol.
module tb_phase_receiver;

    localparam int unsigned IcountW    = 16;
    localparam int unsigned StallLimit = 8;
    localparam int unsigned MRun       = 0;
    localparam int unsigned MHalt      = 1;
    localparam int unsigned MErr       = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    phase_receiver_if #(.ICOUNT_W(IcountW)) bus ();

    phase_receiver #(
        .ICOUNT_W   (IcountW),
        .STALL_LIMIT(StallLimit)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_pulses = 0;

    // Model state
    int unsigned m_mode, m_idx, m_count, m_en, m_halt, m_proto, m_err, m_idle;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_mode  = MRun;
        m_idx   = 0;
        m_count = 0;
        m_en    = 0;
        m_halt  = 0;
        m_proto = 0;
        m_err   = 0;
        m_idle  = 0;
    endtask

    task automatic model_err(input int unsigned code);
        m_mode  = MErr;
        m_err   = code;
        m_proto = 1;
        m_halt  = 1;
        m_idle  = 0;
    endtask

    task automatic model_step(input logic [4:0] pin, input logic halt, input logic hold);
        int n;
        n    = $countones(pin);
        m_en = 0;
        if (m_mode == MRun) begin
            if (n > 1) begin
                model_err(1);
            end else if (n == 1) begin
                m_idle = 0;
                if (32'(pin) == (32'd1 << m_idx)) begin
                    m_en = 32'(pin);
                    if (m_idx == 4) begin
                        m_count = (m_count + 1) % (32'd1 << IcountW);
                        if (halt) begin
                            m_mode = MHalt;
                            m_halt = 1;
                        end
                    end
                    m_idx = (m_idx + 1) % 5;
                end else begin
                    model_err(2);
                end
            end else begin
`ifdef PHASE_RECEIVER_STALL_WATCHDOG_EN
                if (m_idx != 0 && !hold) begin
                    m_idle++;
                    if (m_idle == StallLimit) model_err(4);
                end else begin
                    m_idle = 0;
                end
`else
                if (hold) m_idle = 0;
`endif
            end
        end else if (m_mode == MHalt) begin
            if (n > 1) model_err(1);
            else if (n == 1) model_err(3);
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".phase_en"},   32'(bus.phase_en),   m_en);
        check_eq({tag, ".phase_idx"},  32'(bus.phase_idx),  m_idx);
        check_eq({tag, ".inst_count"}, 32'(bus.inst_count), m_count);
        check_eq({tag, ".haltout"},    32'(bus.haltout),    m_halt);
        check_eq({tag, ".proto_err"},  32'(bus.proto_err),  m_proto);
        check_eq({tag, ".err_code"},   32'(bus.err_code),   m_err);
    endtask

    task automatic cycle(input string tag, input logic [4:0] pin, input logic halt,
                         input logic hold);
        bus.phase_in  = pin;
        bus.halt_req  = halt;
        bus.exec_hold = hold;
        @(posedge clock);
        #1;
        model_step(pin, halt, hold);
        if (bus.phase_en != 5'd0) n_pulses++;
        compare_all(tag);
    endtask

    // Asserted away from the clock edge; outputs must clear before any edge arrives.
    task automatic do_reset();
        bus.phase_in  = '0;
        bus.halt_req  = 1'b0;
        bus.exec_hold = 1'b0;
        reset_n       = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [4:0] pin;
        int unsigned r;
        bus.phase_in  = '0;
        bus.halt_req  = 1'b0;
        bus.exec_hold = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Normal sequence: three instructions with idle cycles between strobes
        n_pulses = 0;
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 5; k++) begin
                cycle("norm", 5'd1 << k, 1'b0, 1'b0);
                cycle("norm_idle", 5'd0, 1'b0, 1'b0);
            end
        end
        check_eq("norm_pulses", n_pulses, 15);
        check_eq("norm_count", 32'(bus.inst_count), 3);
        check_eq("norm_idx", 32'(bus.phase_idx), 0);
        check_eq("norm_err", 32'(bus.err_code), 0);

        // Halt on the second retiring strobe, then a strobe after halt
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 5; k++) begin
                cycle("halt", 5'd1 << k, (rep == 1 && k == 4), 1'b0);
            end
        end
        check_eq("halt_count", 32'(bus.inst_count), 2);
        check_eq("halt_haltout", 32'(bus.haltout), 1);
        check_eq("halt_proto", 32'(bus.proto_err), 0);
        cycle("halt_idle", 5'd0, 1'b0, 1'b0);
        cycle("posthalt", 5'b00001, 1'b0, 1'b0);
        check_eq("posthalt_err", 32'(bus.err_code), 3);
        check_eq("posthalt_proto", 32'(bus.proto_err), 1);

        // Order error after phase 0
        do_reset();
        cycle("order", 5'b00001, 1'b0, 1'b0);
        cycle("order", 5'b00100, 1'b0, 1'b0);
        check_eq("order_err", 32'(bus.err_code), 2);
        check_eq("order_en", 32'(bus.phase_en), 0);
        check_eq("order_idx", 32'(bus.phase_idx), 1);

        // Overlap, then outputs stay frozen under further strobes
        do_reset();
        cycle("overlap", 5'b00011, 1'b0, 1'b0);
        check_eq("overlap_err", 32'(bus.err_code), 1);
        check_eq("overlap_haltout", 32'(bus.haltout), 1);
        for (int i = 0; i < 20; i++) begin
            cycle("frozen", 5'd1 << (i % 5), 1'(i % 2), 1'b0);
        end
        check_eq("frozen_err", 32'(bus.err_code), 1);

        // Reset mid-instruction, then phase 0 is accepted
        do_reset();
        cycle("midrst", 5'b00001, 1'b0, 1'b0);
        cycle("midrst", 5'b00010, 1'b0, 1'b0);
        cycle("midrst", 5'b00100, 1'b0, 1'b0);
        do_reset();
        check_eq("midrst_idx", 32'(bus.phase_idx), 0);
        cycle("midrst_p0", 5'b00001, 1'b0, 1'b0);
        check_eq("midrst_p0_en", 32'(bus.phase_en), 1);

`ifdef PHASE_RECEIVER_STALL_WATCHDOG_EN
        do_reset();
        cycle("wdog", 5'b00001, 1'b0, 1'b0);
        cycle("wdog", 5'b00010, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("wdog_idle", 5'd0, 1'b0, 1'b0);
        check_eq("wdog_err", 32'(bus.err_code), 4);
        do_reset();
        cycle("wdog_hold", 5'b00001, 1'b0, 1'b0);
        cycle("wdog_hold", 5'b00010, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle("wdog_hold", 5'd0, 1'b0, 1'b1);
        check_eq("wdog_hold_err", 32'(bus.err_code), 0);
        cycle("wdog_resume", 5'b00100, 1'b0, 1'b0);
        check_eq("wdog_resume_idx", 32'(bus.phase_idx), 3);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_mode != MRun && $urandom_range(9) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(99);
                if (r < 55)      pin = 5'd1 << m_idx;
                else if (r < 88) pin = 5'd0;
                else if (r < 95) pin = 5'($urandom_range(31));
                else             pin = 5'd1 << $urandom_range(4);
                cycle("rand", pin, ($urandom_range(3) == 0), ($urandom_range(4) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
